// File: rtl/bcd_digit_feeder.sv
// Sequential double-dabble binary-to-BCD converter that feeds the 6-digit seven-segment scanner.
// Leading-zero blanking output is built only when LEADING_ZERO_BLANK_EN is defined.

module bcd_digit_feeder #(
  parameter int BIN_W   = 20,
  parameter int DIGITS  = 6,
  parameter int MAX_VAL = 999999
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  ovf
`ifdef LEADING_ZERO_BLANK_EN
  ,
  output logic [DIGITS-1:0]     blank_n
`endif
);

  localparam int ACC_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [BIN_W-1:0] LP_MAX      = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LP_LAST_BIT = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_finish;
  logic               w_over;
  logic [BIN_W-1:0]   w_bin_sat;
  logic [ACC_W-1:0]   w_acc_step;

  logic [ACC_W-1:0]   r_acc;
  logic [BIN_W-1:0]   r_bin;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_ovf_pending;
  logic               r_busy;
  logic               r_done;
  logic [ACC_W-1:0]   r_bcd;
  logic               r_ovf;

  // One double-dabble step: add 3 to every digit >= 5, then shift in the binary MSB.
  function automatic logic [ACC_W-1:0] f_dabble_step(input logic [ACC_W-1:0] acc,
                                                     input logic             msb);
    logic [ACC_W-1:0] adj;
    logic [3:0]       nib;
    adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      nib = acc[d*4 +: 4];
      if (nib >= 4'd5) begin
        adj[d*4 +: 4] = nib + 4'd3;
      end else begin
        adj[d*4 +: 4] = nib;
      end
    end
    return {adj[ACC_W-2:0], msb};
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is lit if it or any more significant digit is non-zero; digit 0 is always lit.
  function automatic logic [DIGITS-1:0] f_blank_mask(input logic [ACC_W-1:0] val);
    logic [DIGITS-1:0] mask;
    mask    = '0;
    mask[0] = 1'b1;
    for (int i = 1; i < DIGITS; i++) begin
      mask[i] = |(val >> (4 * i));
    end
    return mask;
  endfunction

  logic [DIGITS-1:0] r_blank_n;
`endif

  assign w_over     = (bin_in > LP_MAX);
  assign w_bin_sat  = w_over ? LP_MAX : bin_in;
  assign w_acc_step = f_dabble_step(r_acc, r_bin[BIN_W-1]);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_SHIFT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (r_bit_cnt == LP_LAST_BIT) begin
          w_state_nxt = S_FINISH;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Per-state datapath strobes.
  always_comb begin
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:   w_load   = start;
      S_SHIFT:  w_shift  = 1'b1;
      S_FINISH: w_finish = 1'b1;
      default:  w_load   = 1'b0;
    endcase
  end

  // Conversion datapath: latch on start, one bit per clock while shifting.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_acc         <= '0;
      r_bin         <= '0;
      r_bit_cnt     <= '0;
      r_ovf_pending <= 1'b0;
    end else if (w_load) begin
      r_acc         <= '0;
      r_bin         <= w_bin_sat;
      r_bit_cnt     <= '0;
      r_ovf_pending <= w_over;
    end else if (w_shift) begin
      r_acc         <= w_acc_step;
      r_bin         <= {r_bin[BIN_W-2:0], 1'b0};
      r_bit_cnt     <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      r_ovf_pending <= r_ovf_pending;
    end else begin
      r_acc         <= r_acc;
      r_bin         <= r_bin;
      r_bit_cnt     <= r_bit_cnt;
      r_ovf_pending <= r_ovf_pending;
    end
  end

  // Handshake and result registers; the result only moves on the finishing edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_bcd  <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_busy <= 1'b1;
      end else if (w_finish) begin
        r_busy <= 1'b0;
      end else begin
        r_busy <= r_busy;
      end
      if (w_finish) begin
        r_bcd <= r_acc;
        r_ovf <= r_ovf_pending;
      end else begin
        r_bcd <= r_bcd;
        r_ovf <= r_ovf;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Blanking mask tracks the result it belongs to.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_blank_n <= {{(DIGITS-1){1'b0}}, 1'b1};
    end else if (w_finish) begin
      r_blank_n <= f_blank_mask(r_acc);
    end else begin
      r_blank_n <= r_blank_n;
    end
  end

  assign blank_n = r_blank_n;
`endif

  assign busy    = r_busy;
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Scoreboard bench for bcd_digit_feeder: expected results are queued at launch and checked at done.
// Build with LEADING_ZERO_BLANK_EN defined to also check blank_n.

module tb_bcd_digit_feeder;

  logic        sys_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        start     = 1'b0;
  logic [19:0] bin_in    = 20'd0;
  logic        busy;
  logic        done;
  logic [23:0] bcd_out;
  logic        ovf;
`ifdef LEADING_ZERO_BLANK_EN
  logic [5:0]  blank_n;
`endif

  typedef struct packed {
    logic [23:0] bcd;
    logic        ovf;
    logic [5:0]  blank;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  bcd_digit_feeder dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .ovf       (ovf)
`ifdef LEADING_ZERO_BLANK_EN
    ,
    .blank_n   (blank_n)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input int unsigned v);
    exp_t        e;
    int unsigned s;
    int unsigned p;
    e     = '0;
    e.ovf = (v > 999999);
    s     = e.ovf ? 999999 : v;
    p     = 1;
    for (int i = 0; i < 6; i++) begin
      e.bcd[i*4 +: 4] = 4'((s / p) % 10);
      e.blank[i]      = (i == 0) || (s >= p);
      p               = p * 10;
    end
    return e;
  endfunction

  task automatic launch(input logic [19:0] v);
    bin_in = v;
    start  = 1'b1;
    sb_q.push_back(model(32'(v)));
  endtask

  task automatic await_done(input bit drop, output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge sys_clk);
      if (drop) start = 1'b0;
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    start     = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (bcd_out !== 24'h000000) $display("FAIL reset_bcd: got %h want 000000", bcd_out); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", ovf); else n_pass++;
`ifdef LEADING_ZERO_BLANK_EN
    n_total++; if (blank_n !== 6'b000001) $display("FAIL reset_blank: got %b want 000001", blank_n); else n_pass++;
`endif
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_conversions();
    logic [19:0] vals [6];
    exp_t        e;
    int          lat;
    int          bcnt;
    vals = '{20'd123456, 20'd0, 20'd999999, 20'd1000000, 20'd1048575, 20'd42};
    foreach (vals[i]) begin
      launch(vals[i]);
      await_done(1'b1, lat, bcnt);
      n_total++;
      if (lat < 0) begin
        $display("FAIL conv_timeout: value %0d got no done, want done", vals[i]);
      end else begin
        n_pass++;
        e = sb_q.pop_front();
        n_total++; if (lat != 22) $display("FAIL conv_latency: value %0d got %0d want 22", vals[i], lat); else n_pass++;
        n_total++; if (bcnt != 21) $display("FAIL conv_busy_len: value %0d got %0d want 21", vals[i], bcnt); else n_pass++;
        n_total++; if (bcd_out !== e.bcd) $display("FAIL conv_bcd: value %0d got %h want %h", vals[i], bcd_out, e.bcd); else n_pass++;
        n_total++; if (ovf !== e.ovf) $display("FAIL conv_ovf: value %0d got %b want %b", vals[i], ovf, e.ovf); else n_pass++;
`ifdef LEADING_ZERO_BLANK_EN
        n_total++; if (blank_n !== e.blank) $display("FAIL conv_blank: value %0d got %b want %b", vals[i], blank_n, e.blank); else n_pass++;
`endif
        @(negedge sys_clk);
        n_total++; if (done !== 1'b0) $display("FAIL conv_done_pulse: value %0d got %b want 0", vals[i], done); else n_pass++;
      end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t e;
    int   dones     = 0;
    int   first_lat = -1;
    launch(20'd42);
    for (int n = 1; n <= 50; n++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin
        dones++;
        if (first_lat < 0) first_lat = n;
      end
      if (n == 1) start = 1'b0;
      if (n == 5) begin
        bin_in = 20'd7;
        start  = 1'b1;
      end
      if (n == 6) start = 1'b0;
    end
    e = sb_q.pop_front();
    n_total++; if (dones != 1) $display("FAIL ignore_done_count: got %0d want 1", dones); else n_pass++;
    n_total++; if (first_lat != 22) $display("FAIL ignore_latency: got %0d want 22", first_lat); else n_pass++;
    n_total++; if (bcd_out !== e.bcd) $display("FAIL ignore_bcd: got %h want %h", bcd_out, e.bcd); else n_pass++;
`ifdef LEADING_ZERO_BLANK_EN
    n_total++; if (blank_n !== e.blank) $display("FAIL ignore_blank: got %b want %b", blank_n, e.blank); else n_pass++;
`endif
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    int   bcnt;
    launch(20'd55);
    await_done(1'b0, lat, bcnt);
    e = sb_q.pop_front();
    n_total++; if (lat != 22) $display("FAIL b2b_first_latency: got %0d want 22", lat); else n_pass++;
    n_total++; if (bcd_out !== e.bcd) $display("FAIL b2b_first_bcd: got %h want %h", bcd_out, e.bcd); else n_pass++;
    launch(20'd100);
    await_done(1'b0, lat, bcnt);
    start = 1'b0;
    e = sb_q.pop_front();
    n_total++; if (lat != 22) $display("FAIL b2b_spacing: got %0d want 22", lat); else n_pass++;
    n_total++; if (bcd_out !== e.bcd) $display("FAIL b2b_second_bcd: got %h want %h", bcd_out, e.bcd); else n_pass++;
    n_total++; if (ovf !== e.ovf) $display("FAIL b2b_second_ovf: got %b want %b", ovf, e.ovf); else n_pass++;
    @(negedge sys_clk);
    n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle_after_release: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid();
    exp_t e;
    int   dones = 0;
    int   lat;
    int   bcnt;
    launch(20'd777777);
    for (int n = 1; n <= 10; n++) begin
      @(negedge sys_clk);
      if (n == 1) start = 1'b0;
    end
    sys_rst_n = 1'b0;
    void'(sb_q.pop_back());
    repeat (2) @(negedge sys_clk);
    n_total++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (bcd_out !== 24'h000000) $display("FAIL midrst_bcd: got %h want 000000", bcd_out); else n_pass++;
    n_total++; if (ovf !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", ovf); else n_pass++;
`ifdef LEADING_ZERO_BLANK_EN
    n_total++; if (blank_n !== 6'b000001) $display("FAIL midrst_blank: got %b want 000001", blank_n); else n_pass++;
`endif
    sys_rst_n = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      @(negedge sys_clk);
      if (done === 1'b1) dones++;
    end
    n_total++; if (dones != 0) $display("FAIL midrst_no_done: got %0d want 0", dones); else n_pass++;
    launch(20'd654321);
    await_done(1'b1, lat, bcnt);
    n_total++;
    if (lat < 0) begin
      $display("FAIL midrst_timeout: got no done, want done");
    end else begin
      n_pass++;
      e = sb_q.pop_front();
      n_total++; if (bcd_out !== e.bcd) $display("FAIL midrst_bcd_after: got %h want %h", bcd_out, e.bcd); else n_pass++;
      n_total++; if (ovf !== e.ovf) $display("FAIL midrst_ovf_after: got %b want %b", ovf, e.ovf); else n_pass++;
    end
    n_total++; if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size()); else n_pass++;
  endtask

  initial begin
    @(negedge sys_clk);
    test_reset();
    test_conversions();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
